// File: rtl/vdu_char_fetch.sv
// Text-mode character fetch and pixel serialiser: code from screen RAM, then font byte, one pixel per pix_en.
// First byte is ready 5 clk after line_start; pixel/pixel_valid are registered 1 clk after each strobe.
module vdu_char_fetch #(
  parameter int COLS   = 40,
  parameter int ROWS   = 24,
  parameter int CHAR_H = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         line_start,
  input  logic                         pix_en,
  output logic [$clog2(COLS*ROWS)-1:0] vram_addr,
  input  logic [7:0]                   vram_data,
  output logic [10:0]                  font_addr,
  input  logic [7:0]                   font_data,
  output logic                         pixel,
  output logic                         pixel_valid,
  output logic                         underrun
);
  localparam int AW = $clog2(COLS*ROWS);
  localparam int CW = $clog2(COLS+1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  // VWAIT/FWAIT cover the one-cycle read latency of each memory.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_VRAM  = 3'd1;
  localparam logic [2:0] S_VWAIT = 3'd2;
  localparam logic [2:0] S_FONT  = 3'd3;
  localparam logic [2:0] S_FWAIT = 3'd4;
  localparam logic [2:0] S_LATCH = 3'd5;
  localparam logic [2:0] S_HOLD  = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] fetch_col_q, fetch_col_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    scan_q, scan_d;
  logic [RW-1:0] char_row_q, char_row_d;
  logic          line_active_q, line_active_d;
  logic          frame_done_q, frame_done_d;
  logic          underrun_q, underrun_d;
  logic          inv_q, inv_d;
  logic [7:0]    next_byte_q, next_byte_d;
  logic          next_valid_q, next_valid_d;
  logic [7:0]    shift_q, shift_d;
  logic          pixel_q, pixel_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic [AW-1:0] vram_addr_q, vram_addr_d;
  logic [10:0]   font_addr_q, font_addr_d;
  logic [7:0]    shift_v;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    fetch_col_d   = fetch_col_q;
    bit_cnt_d     = bit_cnt_q;
    scan_d        = scan_q;
    char_row_d    = char_row_q;
    line_active_d = line_active_q;
    frame_done_d  = frame_done_q;
    underrun_d    = underrun_q;
    inv_d         = inv_q;
    next_byte_d   = next_byte_q;
    next_valid_d  = next_valid_q;
    shift_d       = shift_q;
    pixel_d       = pixel_q;
    pixel_valid_d = pixel_valid_q;
    vram_addr_d   = vram_addr_q;
    font_addr_d   = font_addr_q;
    shift_v       = shift_q;

    case (state_q)
      S_VRAM: begin
        vram_addr_d = AW'(char_row_q * COLS) + AW'(fetch_col_q);
        state_d     = S_VWAIT;
      end
      S_VWAIT: state_d = S_FONT;
      S_FONT: begin
        inv_d       = vram_data[7];
        font_addr_d = {vram_data[6:0], scan_q};
        state_d     = S_FWAIT;
      end
      S_FWAIT: state_d = S_LATCH;
      S_LATCH: begin
        next_byte_d  = font_data ^ {8{inv_q}};
        next_valid_d = 1'b1;
        fetch_col_d  = fetch_col_q + CW'(1);
        state_d      = S_HOLD;
      end
      S_HOLD: begin
        if (!next_valid_q) state_d = (fetch_col_q < CW'(COLS)) ? S_VRAM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pix_en && line_active_q) begin
      if (bit_cnt_q == 3'd0) begin
        if (next_valid_q) begin
          shift_v      = next_byte_q;
          next_valid_d = 1'b0;
        end else begin
          shift_v    = 8'h00;
          underrun_d = 1'b1;
        end
      end else begin
        shift_v = shift_q << 1;
      end
      shift_d       = shift_v;
      pixel_d       = shift_v[7];
      pixel_valid_d = 1'b1;
      bit_cnt_d     = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        col_d = col_q + CW'(1);
        if (col_q == CW'(COLS-1)) begin
          line_active_d = 1'b0;
          if (scan_q == 4'(CHAR_H-1)) begin
            scan_d = 4'd0;
            if (char_row_q == RW'(ROWS-1)) begin
              frame_done_d = 1'b1;
              char_row_d   = '0;
            end else begin
              char_row_d = char_row_q + RW'(1);
            end
          end else begin
            scan_d = scan_q + 4'd1;
          end
        end
      end
    end else if (!line_active_q) begin
      pixel_valid_d = 1'b0;
      pixel_d       = 1'b0;
    end

    if (frame_start) begin
      scan_d       = 4'd0;
      char_row_d   = '0;
      underrun_d   = 1'b0;
      frame_done_d = 1'b0;
    end

    // A frame_start in the same cycle re-enables the line immediately.
    if (line_start && !frame_done_d) begin
      col_d         = '0;
      bit_cnt_d     = 3'd0;
      line_active_d = 1'b1;
      next_valid_d  = 1'b0;
      fetch_col_d   = '0;
      state_d       = S_VRAM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      fetch_col_q   <= '0;
      bit_cnt_q     <= 3'd0;
      scan_q        <= 4'd0;
      char_row_q    <= '0;
      line_active_q <= 1'b0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
      inv_q         <= 1'b0;
      next_byte_q   <= 8'h00;
      next_valid_q  <= 1'b0;
      shift_q       <= 8'h00;
      pixel_q       <= 1'b0;
      pixel_valid_q <= 1'b0;
      vram_addr_q   <= '0;
      font_addr_q   <= 11'd0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      fetch_col_q   <= fetch_col_d;
      bit_cnt_q     <= bit_cnt_d;
      scan_q        <= scan_d;
      char_row_q    <= char_row_d;
      line_active_q <= line_active_d;
      frame_done_q  <= frame_done_d;
      underrun_q    <= underrun_d;
      inv_q         <= inv_d;
      next_byte_q   <= next_byte_d;
      next_valid_q  <= next_valid_d;
      shift_q       <= shift_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      vram_addr_q   <= vram_addr_d;
      font_addr_q   <= font_addr_d;
    end
  end

  assign vram_addr   = vram_addr_q;
  assign font_addr   = font_addr_q;
  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign underrun    = underrun_q;
endmodule

// File: tb/tb_vdu_char_fetch.sv
// Directed bench for vdu_char_fetch: default-size instance plus a 2x2x3 instance for end-of-frame behaviour.
module tb_vdu_char_fetch;
  localparam int COLS = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, frame_start, line_start, pix_en;
  logic [9:0] vram_addr;
  logic [7:0] vram_data, font_data;
  logic [10:0] font_addr;
  logic       pixel, pixel_valid, underrun;

  logic       fs_s, ls_s, pe_s;
  logic [1:0] va_s;
  logic [7:0] vd_s, fd_s;
  logic [10:0] fa_s;
  logic       pix_s, pv_s, ur_s;

  vdu_char_fetch dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start), .pix_en(pix_en),
    .vram_addr(vram_addr), .vram_data(vram_data), .font_addr(font_addr), .font_data(font_data),
    .pixel(pixel), .pixel_valid(pixel_valid), .underrun(underrun)
  );

  vdu_char_fetch #(.COLS(2), .ROWS(2), .CHAR_H(3)) dut_s (
    .clk(clk), .rst(rst), .frame_start(fs_s), .line_start(ls_s), .pix_en(pe_s),
    .vram_addr(va_s), .vram_data(vd_s), .font_addr(fa_s), .font_data(fd_s),
    .pixel(pix_s), .pixel_valid(pv_s), .underrun(ur_s)
  );

  logic [7:0] vram_mem [0:959];
  logic [7:0] font_mem [0:2047];
  logic [7:0] vram_s_mem [0:3];

  always @(posedge clk) begin
    vram_data <= vram_mem[vram_addr];
    font_data <= font_mem[font_addr];
    vd_s      <= vram_s_mem[va_s];
    fd_s      <= font_mem[fa_s];
  end

  typedef struct {
    string      name;
    logic [7:0] code;
    logic [7:0] font;
    logic [7:0] exp;
  } cell_vec_t;
  cell_vec_t tbl [8];

  int checks = 0;
  int errors = 0;
  logic pix_buf [0:399];
  int vcount;
  logic [9:0] va1;
  logic [10:0] fa2, fa3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input string n, input logic [7:0] c, input logic [7:0] f,
                         input logic [7:0] e);
    tbl[i].name = n;
    tbl[i].code = c;
    tbl[i].font = f;
    tbl[i].exp  = e;
  endtask

  // line_start (optionally with frame_start), lead-1 idle clk, then pix_en every clk for nstrobes.
  task automatic run_line(input logic fs, input int lead, input int nstrobes);
    frame_start = fs;
    line_start  = 1'b1;
    tick();
    frame_start = 1'b0;
    line_start  = 1'b0;
    for (int k = 1; k < lead; k++) begin
      tick();
      if (k == 1) va1 = vram_addr;
      if (k == 2) fa2 = font_addr;
      if (k == 3) fa3 = font_addr;
    end
    pix_en = 1'b1;
    vcount = 0;
    for (int i = 0; i < nstrobes; i++) begin
      tick();
      pix_buf[i] = pixel;
      if (pixel_valid) vcount++;
    end
    pix_en = 1'b0;
  endtask

  function automatic logic [7:0] model_byte(input int row, input int scan, input int col);
    logic [7:0]  c;
    logic [10:0] a;
    c = vram_mem[row*COLS + col];
    a = {c[6:0], 4'(scan)};
    return c[7] ? ~font_mem[a] : font_mem[a];
  endfunction

  function automatic logic [7:0] got_byte(input int col);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = pix_buf[col*8 + j];
    return b;
  endfunction

  task automatic check_line(input string name, input int row, input int scan);
    int bad;
    bad = 0;
    for (int c = 0; c < COLS; c++) if (got_byte(c) !== model_byte(row, scan, c)) bad++;
    chk(name, bad, 0);
  endtask

  initial begin
    for (int i = 0; i < 960; i++) vram_mem[i] = 8'(i*7 + 3);
    for (int a = 0; a < 2048; a++) font_mem[a] = 8'(a*13 + 5);
    for (int i = 0; i < 4; i++) vram_s_mem[i] = 8'(i + 1);
    set_vec(0, "cell_plain",     8'h41, 8'h3C, 8'h3C);
    set_vec(1, "cell_inverse",   8'hC1, 8'h3C, 8'hC3);
    set_vec(2, "cell_blank",     8'h00, 8'h00, 8'h00);
    set_vec(3, "cell_inv_blank", 8'h80, 8'h00, 8'hFF);
    set_vec(4, "cell_edges",     8'h7F, 8'h81, 8'h81);
    set_vec(5, "cell_inv_edges", 8'hFF, 8'h81, 8'h7E);
    set_vec(6, "cell_alt",       8'h12, 8'hA5, 8'hA5);
    set_vec(7, "cell_lsb",       8'h13, 8'h01, 8'h01);
    for (int c = 0; c < 8; c++) begin
      vram_mem[c] = tbl[c].code;
      font_mem[{tbl[c].code[6:0], 4'h0}] = tbl[c].font;
    end

    rst = 1'b1; frame_start = 1'b0; line_start = 1'b0; pix_en = 1'b0;
    fs_s = 1'b0; ls_s = 1'b0; pe_s = 1'b0;
    repeat (3) tick();
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_font_addr", font_addr, 0);
    chk("rst_pixel", pixel, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;
    tick();

    // Frame start, then line 0 (row 0, scan 0).
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    run_line(1'b0, 6, 324);
    chk("vram_addr_t1", va1, 0);
    chk("font_addr_t2", fa2, 0);
    chk("font_addr_t3", fa3, 11'h410);
    for (int c = 0; c < 8; c++) chk(tbl[c].name, got_byte(c), tbl[c].exp);
    chk("valid_count", vcount, 320);
    tick();
    chk("valid_off", pixel_valid, 0);
    check_line("line0", 0, 0);
    chk("no_underrun", underrun, 0);

    for (int ln = 1; ln <= 10; ln++) begin
      run_line(1'b0, 6, 324);
      tick();
      if (ln == 1) begin
        check_line("line1_scan1", 0, 1);
        chk("line1_font_lo", fa3[3:0], 1);
      end
      if (ln == 10) begin
        chk("line10_vram", va1, 40);
        chk("line10_font_lo", fa3[3:0], 0);
        check_line("line10", 1, 0);
      end
    end

    // Restart at col 17 of line 11 (row 1, scan 1): same scan, fresh fetch from col 0.
    run_line(1'b0, 6, 136);
    run_line(1'b0, 6, 324);
    tick();
    chk("restart_vram", va1, 40);
    chk("restart_cell0", got_byte(0), model_byte(1, 1, 0));
    check_line("restart_line", 1, 1);
    chk("restart_valid_count", vcount, 320);

    // Underrun: pix_en only 2 clk after line_start.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    run_line(1'b0, 2, 324);
    tick();
    chk("underrun_cell0", got_byte(0), 0);
    chk("underrun_flag", underrun, 1);
    run_line(1'b0, 6, 324);
    tick();
    chk("underrun_sticky", underrun, 1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("underrun_clr", underrun, 0);

    // Advance to scan 1, then frame_start together with line_start restarts at row 0 scan 0.
    run_line(1'b0, 6, 324);
    tick();
    run_line(1'b1, 6, 324);
    tick();
    chk("fs_ls_vram", va1, 0);
    check_line("fs_ls_line", 0, 0);

    // Reset at col 5 while underrun is set.
    run_line(1'b0, 2, 41);
    chk("pre_rst_valid", pixel_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_vram_addr", vram_addr, 0);
    chk("midrst_font_addr", font_addr, 0);
    chk("midrst_pixel", pixel, 0);
    chk("midrst_pixel_valid", pixel_valid, 0);
    chk("midrst_underrun", underrun, 0);
    pix_en = 1'b1;
    repeat (8) tick();
    chk("midrst_idle_vram", vram_addr, 0);
    chk("midrst_idle_valid", pixel_valid, 0);
    pix_en = 1'b0;
    run_line(1'b0, 6, 324);
    tick();
    check_line("after_rst_line", 0, 0);

    // Small instance: 6 lines per frame, the 7th line is ignored.
    fs_s = 1'b1; tick(); fs_s = 1'b0;
    for (int ln = 0; ln < 8; ln++) begin
      logic [1:0] va_t1;
      int cnt;
      fs_s = (ln == 7);
      ls_s = 1'b1; tick(); ls_s = 1'b0; fs_s = 1'b0;
      tick();
      va_t1 = va_s;
      repeat (4) tick();
      pe_s = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (pv_s) cnt++;
      end
      pe_s = 1'b0;
      tick();
      if (ln == 5) begin
        chk("small_last_line_vram", va_t1, 2);
        chk("small_last_line_valid", cnt, 16);
      end
      if (ln == 6) begin
        chk("small_done_no_fetch", va_t1, 3);
        chk("small_done_no_valid", cnt, 0);
      end
      if (ln == 7) begin
        chk("small_new_frame_vram", va_t1, 0);
        chk("small_new_frame_valid", cnt, 16);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
